param_icache: RTL and testbench

Parametrised, direct-mapped, read-only instruction cache between the CPU fetch port and a block-wide instruction memory. It replaces the flat byte-array instruction memory that feeds the CPU directly. Hits return the instruction in the same cycle. Misses stall the CPU through BUSYWAIT while an FSM fetches a whole block over a busywait handshake. A FLUSH input invalidates all lines, for program reload.

---
 rtl/param_icache_pkg.sv | 28 ++
 rtl/param_icache_lines.sv | 58 +++++
 rtl/param_icache.sv | 130 +++++++++++++
 tb/tb_param_icache.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_icache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | param_icache_pkg                                                         |
// | Shared state encoding and address-field width helpers for param_icache.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package param_icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    function automatic int off_w(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_sets, input int block_words);
        return addr_w - off_w(block_words) - idx_w(num_sets);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_icache_lines.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | param_icache_lines                                                       |
// | Valid/tag/data storage with async read, one block write and flush-all.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module param_icache_lines #(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 3,
    parameter int LINE_W   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_data
);

    logic              r_valid [NUM_SETS];
    logic [TAG_W-1:0]  r_tag   [NUM_SETS];
    logic [LINE_W-1:0] r_data  [NUM_SETS];

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_line
        logic w_sel;
        assign w_sel = i_wr_en && (i_wr_idx == IDX_W'(s));

        // A fill landing on the flush edge keeps its own line valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[s] <= 1'b0;
            end else if (w_sel) begin
                r_valid[s] <= 1'b1;
            end else if (i_flush) begin
                r_valid[s] <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (w_sel) begin
                r_tag[s]  <= i_wr_tag;
                r_data[s] <= i_wr_data;
            end
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/param_icache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | param_icache                                                             |
// | Direct-mapped read-only instruction cache with block refill FSM.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module param_icache
    import param_icache_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [31:0]                           PC,
    output logic [31:0]                           INSTRUCTION,
    output logic                                  BUSYWAIT,
    input  logic                                  FLUSH,
    output logic                                  mem_read,
    output logic [ADDR_W-off_w(BLOCK_WORDS)-1:0]  mem_address,
    input  logic [32*BLOCK_WORDS-1:0]             mem_readdata,
    input  logic                                  mem_busywait
);

    localparam int OFF_W = off_w(BLOCK_WORDS);
    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(ADDR_W, NUM_SETS, BLOCK_WORDS);
    localparam int BLK_W = ADDR_W - OFF_W;
    localparam int SEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int LINE_W = 32 * BLOCK_WORDS;

    state_t             r_state;
    logic               r_mem_read;
    logic [BLK_W-1:0]   r_blk_addr;

    logic [BLK_W-1:0]   w_blk_addr;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [SEL_W-1:0]   w_word;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [LINE_W-1:0]  w_rd_data;
    logic               w_hit;
    logic               w_install;
    logic               w_unused;

    assign w_blk_addr = PC[ADDR_W-1:OFF_W];
    assign w_idx      = w_blk_addr[IDX_W-1:0];
    assign w_tag      = w_blk_addr[BLK_W-1:IDX_W];
    assign w_unused   = ^{PC[31:ADDR_W], PC[1:0]};

    if (BLOCK_WORDS > 1) begin : g_word_sel
        assign w_word = PC[OFF_W-1:2];
    end else begin : g_word_single
        assign w_word = '0;
    end

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // Capture uses the latched block address, never the live PC.
    assign w_install = !RESET && (r_state == MEM_READ) && !mem_busywait;

    param_icache_lines #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) u_lines (
        .clk        (CLK),
        .rst        (RESET),
        .i_flush    (FLUSH),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_install),
        .i_wr_idx   (r_blk_addr[IDX_W-1:0]),
        .i_wr_tag   (r_blk_addr[BLK_W-1:IDX_W]),
        .i_wr_data  (mem_readdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_mem_read <= 1'b0;
            r_blk_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_state    <= MEM_READ;
                        r_mem_read <= 1'b1;
                        r_blk_addr <= w_blk_addr;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        r_state    <= UPDATE;
                        r_mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_address = r_blk_addr;

    always_comb begin
        BUSYWAIT    = 1'b0;
        INSTRUCTION = 32'h0;
        if (!RESET) begin
            if ((r_state == IDLE) && w_hit) begin
                INSTRUCTION = w_rd_data[32*int'(w_word) +: 32];
            end else begin
                BUSYWAIT = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_icache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_param_icache                                                          |
// | Directed, table-driven bench for param_icache (default and 4x2 configs). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_param_icache;

    localparam int LAT   = 4;
    localparam int LAT_B = 1;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic         FLUSH;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    int           cnt_a;

    logic [31:0]  pc_b;
    logic [31:0]  instr_b;
    logic         busy_b;
    logic         mr_b;
    logic [6:0]   addr_b;
    logic [63:0]  rd_b;
    logic         mbw_b;
    int           cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] blk_word(input int b, input int w);
        return {16'hC0DE, b[7:0], w[7:0]};
    endfunction

    // Memory models: busywait rises with mem_read and holds for LAT edges.
    always_ff @(posedge CLK) begin
        if (!mem_read) cnt_a <= 0;
        else if (mem_busywait) cnt_a <= cnt_a + 1;
        if (!mr_b) cnt_b <= 0;
        else if (mbw_b) cnt_b <= cnt_b + 1;
    end
    assign mem_busywait = mem_read && (cnt_a < LAT);
    assign mbw_b        = mr_b && (cnt_b < LAT_B);

    always_comb begin
        mem_readdata = '0;
        rd_b         = '0;
        for (int w = 0; w < 4; w++) mem_readdata[32*w +: 32] = blk_word(int'(mem_address), w);
        for (int w = 0; w < 2; w++) rd_b[32*w +: 32] = blk_word(int'(addr_b), w);
    end

    param_icache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .FLUSH        (FLUSH),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    param_icache #(.ADDR_W(10), .NUM_SETS(4), .BLOCK_WORDS(2)) dut_b (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (pc_b),
        .INSTRUCTION  (instr_b),
        .BUSYWAIT     (busy_b),
        .FLUSH        (1'b0),
        .mem_read     (mr_b),
        .mem_address  (addr_b),
        .mem_readdata (rd_b),
        .mem_busywait (mbw_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        miss;
        logic [5:0]  blk;
        logic [31:0] instr;
    } vec_t;

    // Called at a falling edge; returns at the falling edge of the next access.
    task automatic access(input vec_t v);
        int  busy_cyc;
        int  mr_cyc;
        bit  done;
        bit  addr_bad;
        if (v.flush) begin
            FLUSH = 1'b1;
            PC    = v.pc;
            @(negedge CLK);
            FLUSH = 1'b0;
        end
        PC = v.pc;
        #1;
        chk("busywait_on_access", BUSYWAIT, v.miss);
        if (v.miss) begin
            chk("instr_zero_on_miss", INSTRUCTION, 32'h0);
            busy_cyc = 1;
            mr_cyc   = 0;
            done     = 0;
            addr_bad = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge CLK);
                #1;
                if (!BUSYWAIT) begin
                    done = 1;
                end else begin
                    busy_cyc++;
                    if (mem_read) begin
                        mr_cyc++;
                        if (mem_address !== v.blk) addr_bad = 1;
                    end
                end
            end
            chk("fill_completed", 32'(done), 32'd1);
            chk("stall_cycles", busy_cyc, LAT + 3);
            chk("mem_read_cycles", mr_cyc, LAT + 1);
            chk("mem_address_during_fill", 32'(addr_bad), 32'd0);
        end else begin
            chk("mem_read_idle_on_hit", mem_read, 1'b0);
        end
        chk("instruction", INSTRUCTION, v.instr);
        @(negedge CLK);
    endtask

    vec_t tbl [13];

    initial begin
        int k;
        bit done;
        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b1, 6'd0,  32'hC0DE_0000};
        tbl[1]  = '{32'h0000_0004, 1'b0, 1'b0, 6'd0,  32'hC0DE_0001};
        tbl[2]  = '{32'h0000_0008, 1'b0, 1'b0, 6'd0,  32'hC0DE_0002};
        tbl[3]  = '{32'h0000_000C, 1'b0, 1'b0, 6'd0,  32'hC0DE_0003};
        tbl[4]  = '{32'h0000_0080, 1'b0, 1'b1, 6'd8,  32'hC0DE_0800};
        tbl[5]  = '{32'h0000_0084, 1'b0, 1'b0, 6'd8,  32'hC0DE_0801};
        tbl[6]  = '{32'h0000_0000, 1'b0, 1'b1, 6'd0,  32'hC0DE_0000};
        tbl[7]  = '{32'hFFFF_FC08, 1'b0, 1'b0, 6'd0,  32'hC0DE_0002};
        tbl[8]  = '{32'h0000_0007, 1'b0, 1'b0, 6'd0,  32'hC0DE_0001};
        tbl[9]  = '{32'h0000_0010, 1'b0, 1'b1, 6'd1,  32'hC0DE_0100};
        tbl[10] = '{32'h0000_0018, 1'b1, 1'b1, 6'd1,  32'hC0DE_0102};
        tbl[11] = '{32'h0000_03F0, 1'b0, 1'b1, 6'd63, 32'hC0DE_3F00};
        tbl[12] = '{32'h0000_03FC, 1'b0, 1'b0, 6'd63, 32'hC0DE_3F03};

        RESET = 1'b1;
        FLUSH = 1'b0;
        PC    = 32'h0;
        pc_b  = 32'h0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_busywait", BUSYWAIT, 1'b0);
        chk("reset_instruction", INSTRUCTION, 32'h0);
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_address", mem_address, 6'd0);
        chk("reset_busywait_b", busy_b, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 13; i++) access(tbl[i]);

        // Second configuration: 4 sets x 2 words, 64-bit block bus.
        pc_b = 32'h0000_0018;
        #1;
        chk("b_miss_busywait", busy_b, 1'b1);
        @(negedge CLK);
        #1;
        chk("b_mem_read", mr_b, 1'b1);
        chk("b_mem_address", addr_b, 7'd3);
        done = 0;
        for (k = 0; k < 20 && !done; k++) begin
            @(negedge CLK);
            #1;
            if (!busy_b) done = 1;
        end
        chk("b_fill_completed", 32'(done), 32'd1);
        chk("b_instr_word0", instr_b, 32'hC0DE_0300);
        @(negedge CLK);
        pc_b = 32'h0000_001C;
        #1;
        chk("b_hit_busywait", busy_b, 1'b0);
        chk("b_instr_upper_word", instr_b, 32'hC0DE_0301);
        @(negedge CLK);

        // Reset abandons a fill in its second MEM_READ cycle.
        PC = 32'h0000_0200;
        #1;
        chk("rst_fill_miss", BUSYWAIT, 1'b1);
        @(negedge CLK);
        #1;
        chk("rst_fill_mem_read1", mem_read, 1'b1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_busywait_low", BUSYWAIT, 1'b0);
        chk("rst_instruction_zero", INSTRUCTION, 32'h0);
        @(negedge CLK);
        #1;
        chk("rst_mem_read_dropped", mem_read, 1'b0);
        RESET = 1'b0;
        PC    = 32'h0000_0014;
        #1;
        chk("rst_lines_invalid", BUSYWAIT, 1'b1);
        chk("rst_state_idle", mem_read, 1'b0);
        done = 0;
        for (k = 0; k < 40 && !done; k++) begin
            @(negedge CLK);
            #1;
            if (!BUSYWAIT) done = 1;
        end
        chk("rst_refill_completed", 32'(done), 32'd1);
        chk("rst_refill_instr", INSTRUCTION, 32'hC0DE_0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
